cache_line_xfer_engine: RTL and testbench
=========================================

// Module: cache_line_xfer_engine
// PURPOSE
//  Parametrised memory-side line transfer engine for the lab3 caches: turns one
//  line command into a burst of 4B mem requests (writeback, refill or
//  evict-then-refill).
//  Pipelines up to MAX_OUT requests in flight and reassembles out-of-order
//  refill responses by opaque tag. Sits between the cache FSM/datapath and the
//  cache_req/cache_resp ports.
// PARAMETERS
//  LINE_WORDS  4  32-bit words per line; power of 2, >=2
//  MAX_OUT     2  max requests in flight; 1..LINE_WORDS
//  (derived: IDXW = clog2(LINE_WORDS), OFFW = IDXW+2, LW = 32*LINE_WORDS)
// PORTS
//  clk             in   1    clock
//  reset           in   1    synchronous, active-high
//  cmd_val         in   1    command valid
//  cmd_rdy         out  1    engine can accept command (IDLE only)
//  cmd_wb          in   1    perform writeback phase
//  cmd_rf          in   1    perform refill phase
//  cmd_wb_addr     in   32   writeback line address (low OFFW bits ignored)
//  cmd_rf_addr     in   32   refill line address (low OFFW bits ignored)
//  cmd_wb_data     in   LW   line to write back; word i = bits [32i+31:32i]
//  done_val        out  1    command complete
//  done_rdy        in   1    consumer accepts completion
//  done_data       out  LW   refilled line (valid with done_val when cmd_rf=1)
//  cache_req_val   out  1    mem request valid
//  cache_req_rdy   in   1    memory accepts request
//  cache_req_msg   out  77   mem_req_4B_t {type 3, opaque 8, addr 32, len 2, data 32}
//  cache_resp_val  in   1    mem response valid
//  cache_resp_rdy  out  1    engine accepts response
//  cache_resp_msg  in   47   mem_resp_4B_t {type 3, opaque 8, test 2, len 2, data 32}
// BEHAVIOUR
//  Reset: state=IDLE, counters 0, line buffer 0; cmd_rdy=1, done_val=0,
//   cache_req_val=0, cache_resp_rdy=0.
//  States: IDLE -> WB -> RF -> DONE -> IDLE; WB/RF skipped per cmd bits.
//   - cmd fires (cmd_val&cmd_rdy): latch addrs, wb data, flags. Next state is
//     WB if cmd_wb, else RF if cmd_rf, else DONE.
//   - WB complete -> RF if cmd_rf else DONE.
//   - RF complete -> DONE.
//   - DONE: done_val=1; done_rdy -> IDLE; cmd_rdy=1 again next cycle.
//  Phase (WB/RF) counters: issued (0..LINE_WORDS), outst (0..MAX_OUT),
//   received (0..LINE_WORDS); all cleared on phase entry.
//  cache_req_val = phase & issued<LINE_WORDS & outst<MAX_OUT. Combinational
//   from regs only, never from cache_req_rdy.
//  Request for word i=issued:
//   - type = WRITE(1) in WB, READ(0) in RF
//   - opaque = zero-extended i
//   - addr = {line_addr[31:OFFW], i[IDXW-1:0], 2'b00}
//   - len = 0
//   - data = wb word i in WB, 0 in RF
//  Word order is 0..LINE_WORDS-1.
//  cache_resp_rdy = 1 in WB/RF, 0 otherwise (stray responses in IDLE/DONE are
//   stalled, never dropped).
//  Req fire: issued++, outst++. Resp fire: received++, outst--. Same-cycle req
//   fire and resp fire: outst unchanged.
//  RF resp fire: buffer word opaque[IDXW-1:0] <= resp data. Arrival order is
//   arbitrary. WB resp data is ignored.
//  Phase complete when received==LINE_WORDS. State changes next cycle; no
//   request is issued in the exit cycle. 1-cycle bubble between WB and RF.
//  Min latency, always-ready memory with 1-cycle resp, MAX_OUT>=2: RF of N
//   words completes in N+2 cycles from cmd fire to done_val.
//  done_data holds buffer contents; stable while done_val=1.
//  Reset mid-operation returns to IDLE next edge, discarding progress. Memory
//   side must be reset together.
// TESTING
//  1 Refill, LINE_WORDS=4, rf_addr=0x0000_1E24, mem in-order resp ->
//    4 READs @0x1E20,24,28,2C, opaque 0..3; done_data = resp words.
//  2 Refill, resps returned order 2,0,3,1 (MAX_OUT=4) -> done_data word i =
//    data for opaque i; done_val only after 4th resp.
//  3 Writeback, wb_addr=0x40, data words 0xDEADBEEF+i -> 4 WRITEs @0x40..0x4C
//    with those data; done_val after 4 write acks.
//  4 Evict+refill, wb=0x100, rf=0x200 -> 4 WRITEs complete before first READ
//    @0x200; one completion only.
//  5 MAX_OUT=2, resp withheld -> exactly 2 reqs issued then cache_req_val=0.
//    Release one resp -> third req the next cycle. cache_req_rdy low -> msg held.
//  6 Assert reset after 2 reqs of a refill -> next cycle cmd_rdy=1,
//    cache_req_val=0, done_val=0. New command runs clean.

Source files
------------

// File: rtl/cache_line_xfer_engine.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_xfer_engine
// Purpose  : Turns one line command into a burst of 4B memory requests
//            (writeback, refill or both) and reassembles tagged refill data.
// Revision : 1.0  initial release
// ============================================================================
module cache_line_xfer_engine #(
    parameter int LINE_WORDS = 4,
    parameter int MAX_OUT    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_val,
    output logic                     cmd_rdy,
    input  logic                     cmd_wb,
    input  logic                     cmd_rf,
    input  logic [31:0]              cmd_wb_addr,
    input  logic [31:0]              cmd_rf_addr,
    input  logic [32*LINE_WORDS-1:0] cmd_wb_data,
    output logic                     done_val,
    input  logic                     done_rdy,
    output logic [32*LINE_WORDS-1:0] done_data,
    output logic                     cache_req_val,
    input  logic                     cache_req_rdy,
    output logic [76:0]              cache_req_msg,
    input  logic                     cache_resp_val,
    output logic                     cache_resp_rdy,
    input  logic [46:0]              cache_resp_msg
);
    localparam int IDXW = $clog2(LINE_WORDS);
    localparam int OFFW = IDXW + 2;
    localparam int CNTW = IDXW + 1;
    localparam int OUTW = $clog2(MAX_OUT + 1);
    localparam logic [CNTW-1:0] C_WORDS   = CNTW'(LINE_WORDS);
    localparam logic [CNTW-1:0] C_LAST    = CNTW'(LINE_WORDS - 1);
    localparam logic [OUTW-1:0] C_MAX_OUT = OUTW'(MAX_OUT);
    localparam logic [2:0]      C_READ    = 3'd0;
    localparam logic [2:0]      C_WRITE   = 3'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_RF   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  state;
    logic                    do_rf;
    logic [31-OFFW:0]        wb_line;
    logic [31-OFFW:0]        rf_line;
    logic [32*LINE_WORDS-1:0] wb_data;
    logic [32*LINE_WORDS-1:0] line_buf;
    logic [CNTW-1:0]         issued;
    logic [CNTW-1:0]         received;
    logic [OUTW-1:0]         outst;

    logic                    in_wb;
    logic                    in_phase;
    logic                    req_fire;
    logic                    resp_fire;
    logic                    last_resp;
    logic [IDXW-1:0]         req_idx;
    logic [IDXW-1:0]         resp_idx;
    logic [31-OFFW:0]        line_addr;
    logic [31:0]             req_data;
    logic                    unused_bits;

    assign in_wb     = (state == S_WB);
    assign in_phase  = in_wb || (state == S_RF);
    assign cache_req_val = in_phase && (issued < C_WORDS) && (outst < C_MAX_OUT);
    assign req_fire  = cache_req_val && cache_req_rdy;
    assign resp_fire = cache_resp_val && cache_resp_rdy;
    assign last_resp = resp_fire && (received == C_LAST);
    assign req_idx   = issued[IDXW-1:0];
    assign resp_idx  = cache_resp_msg[36 +: IDXW];
    assign line_addr = in_wb ? wb_line : rf_line;
    assign req_data  = in_wb ? wb_data[{req_idx, 5'd0} +: 32] : 32'd0;

    // {type, opaque, addr, len, data}
    assign cache_req_msg = {in_wb ? C_WRITE : C_READ, 8'(req_idx),
                            line_addr, req_idx, 2'b00, 2'b00, req_data};
    assign done_data = line_buf;

    assign unused_bits = ^{cmd_wb_addr[OFFW-1:0], cmd_rf_addr[OFFW-1:0],
                           cache_resp_msg[46:44], cache_resp_msg[43:36+IDXW],
                           cache_resp_msg[35:32]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            cmd_rdy        <= 1'b1;
            done_val       <= 1'b0;
            cache_resp_rdy <= 1'b0;
            do_rf          <= 1'b0;
            wb_line        <= '0;
            rf_line        <= '0;
            wb_data        <= '0;
            line_buf       <= '0;
            issued         <= '0;
            outst          <= '0;
            received       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_val && cmd_rdy) begin
                        wb_line  <= cmd_wb_addr[31:OFFW];
                        rf_line  <= cmd_rf_addr[31:OFFW];
                        wb_data  <= cmd_wb_data;
                        do_rf    <= cmd_rf;
                        cmd_rdy  <= 1'b0;
                        issued   <= '0;
                        outst    <= '0;
                        received <= '0;
                        if (cmd_wb) begin
                            state          <= S_WB;
                            cache_resp_rdy <= 1'b1;
                        end else if (cmd_rf) begin
                            state          <= S_RF;
                            cache_resp_rdy <= 1'b1;
                        end else begin
                            state    <= S_DONE;
                            done_val <= 1'b1;
                        end
                    end
                end
                S_WB, S_RF: begin
                    if (req_fire) issued <= issued + 1'b1;
                    if (req_fire && !resp_fire)      outst <= outst + 1'b1;
                    else if (!req_fire && resp_fire) outst <= outst - 1'b1;
                    if (resp_fire) received <= received + 1'b1;
                    // Refill data lands by tag, so arrival order does not matter
                    if (resp_fire && !in_wb)
                        line_buf[{resp_idx, 5'd0} +: 32] <= cache_resp_msg[31:0];
                    if (last_resp) begin
                        issued   <= '0;
                        outst    <= '0;
                        received <= '0;
                        if (in_wb && do_rf) begin
                            state <= S_RF;
                        end else begin
                            state          <= S_DONE;
                            cache_resp_rdy <= 1'b0;
                            done_val       <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (done_rdy) begin
                        state    <= S_IDLE;
                        done_val <= 1'b0;
                        cmd_rdy  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cache_line_xfer_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_line_xfer_engine
// Purpose  : Randomised self-checking bench for cache_line_xfer_engine
// Revision : 1.0  initial release
// ============================================================================
module tb_cache_line_xfer_engine;
    localparam int LINE_WORDS = 4;
    localparam int LW         = 32 * LINE_WORDS;
    localparam int NI         = 2;   // instance 0: MAX_OUT=2, instance 1: MAX_OUT=4

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic [2:0]  typ;
        logic [7:0]  op;
        logic [31:0] data;
        int          due;
    } pend_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_val   [NI];
    logic          cmd_rdy   [NI];
    logic          cmd_wb    [NI];
    logic          cmd_rf    [NI];
    logic [31:0]   wb_addr   [NI];
    logic [31:0]   rf_addr   [NI];
    logic [LW-1:0] wb_data   [NI];
    logic          done_val  [NI];
    logic          done_rdy  [NI];
    logic [LW-1:0] done_data [NI];
    logic          req_val   [NI];
    logic          req_rdy   [NI];
    logic [76:0]   req_msg   [NI];
    logic          resp_val  [NI];
    logic          resp_rdy  [NI];
    logic [46:0]   resp_msg  [NI];

    logic [LW-1:0] model_line [NI];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        cache_line_xfer_engine #(
            .LINE_WORDS(LINE_WORDS),
            .MAX_OUT   (k == 0 ? 2 : 4)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .cmd_val       (cmd_val[k]),
            .cmd_rdy       (cmd_rdy[k]),
            .cmd_wb        (cmd_wb[k]),
            .cmd_rf        (cmd_rf[k]),
            .cmd_wb_addr   (wb_addr[k]),
            .cmd_rf_addr   (rf_addr[k]),
            .cmd_wb_data   (wb_data[k]),
            .done_val      (done_val[k]),
            .done_rdy      (done_rdy[k]),
            .done_data     (done_data[k]),
            .cache_req_val (req_val[k]),
            .cache_req_rdy (req_rdy[k]),
            .cache_req_msg (req_msg[k]),
            .cache_resp_val(resp_val[k]),
            .cache_resp_rdy(resp_rdy[k]),
            .cache_resp_msg(resp_msg[k])
        );
    end

    // Memory + reference model for one command. mode 0: always ready, in-order
    // 1-cycle responses; 1: random stalls and random response order;
    // 2: hold responses until all requests issued, then answer opaque 2,0,3,1.
    task automatic run_cmd(input int sel, input bit wb, input bit rf,
                           input logic [31:0] wa, input logic [31:0] ra,
                           input logic [LW-1:0] wd, input int mode, output int lat);
        req_t          exp_q[$];
        pend_t         pend[$];
        int            perm[$];
        req_t          e;
        logic [31:0]   salt, wbase, rbase;
        logic [LW-1:0] exp_line;
        logic [76:0]   rm, exp_msg, hold_msg;
        logic          rv, prdy, hold;
        int            cyc, pick, k, nw;
        bit            fin, reads_seen;

        salt  = $urandom;
        wbase = wa & ~(32'(4 * LINE_WORDS) - 32'd1);
        rbase = ra & ~(32'(4 * LINE_WORDS) - 32'd1);
        exp_line = model_line[sel];
        for (int i = 0; i < LINE_WORDS; i++)
            if (wb) exp_q.push_back('{3'd1, 8'(i), wbase + 32'(4 * i), wd[32*i +: 32]});
        for (int i = 0; i < LINE_WORDS; i++)
            if (rf) begin
                exp_q.push_back('{3'd0, 8'(i), rbase + 32'(4 * i), 32'd0});
                exp_line[32*i +: 32] = (rbase + 32'(4 * i)) ^ salt;
            end
        perm = {2, 0, 3, 1};

        n_vec++;
        if (cmd_rdy[sel] !== 1'b1) begin
            n_err++;
            $display("FAIL cmd_rdy_idle inst%0d: got %b want 1", sel, cmd_rdy[sel]);
        end
        cmd_val[sel] = 1'b1;
        cmd_wb[sel]  = wb;
        cmd_rf[sel]  = rf;
        wb_addr[sel] = wa;
        rf_addr[sel] = ra;
        wb_data[sel] = wd;
        @(negedge clk);
        cmd_val[sel] = 1'b0;

        cyc = 1; lat = -1; fin = 0; hold = 0; reads_seen = 0;
        while (!fin && cyc < 400) begin
            rv   = req_val[sel];
            rm   = req_msg[sel];
            prdy = resp_rdy[sel];
            if (hold) begin
                n_vec++;
                if (rv !== 1'b1 || rm !== hold_msg) begin
                    n_err++;
                    $display("FAIL req_hold inst%0d: got val=%b msg=%h want val=1 msg=%h",
                             sel, rv, rm, hold_msg);
                end
            end
            req_rdy[sel] = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;

            pick = -1;
            if (pend.size() > 0) begin
                if (mode == 0) begin
                    if (pend[0].due <= cyc) pick = 0;
                end else if (mode == 1) begin
                    k = $urandom_range(0, pend.size() - 1);
                    if (pend[k].due <= cyc && $urandom_range(0, 1) == 1) pick = k;
                end else if (exp_q.size() == 0 && perm.size() > 0) begin
                    foreach (pend[j]) if (int'(pend[j].op) == perm[0]) pick = j;
                end
            end
            resp_val[sel] = (pick >= 0);
            resp_msg[sel] = '0;
            if (pick >= 0) resp_msg[sel] = {pend[pick].typ, pend[pick].op, 4'h0, pend[pick].data};

            hold     = rv && !req_rdy[sel];
            hold_msg = rm;
            if (rv && req_rdy[sel]) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL req_extra inst%0d: got msg=%h want no request", sel, rm);
                end else begin
                    e = exp_q.pop_front();
                    exp_msg = {e.typ, e.op, e.addr, 2'b00, e.data};
                    if (rm !== exp_msg) begin
                        n_err++;
                        $display("FAIL req_msg inst%0d: got %h want %h", sel, rm, exp_msg);
                    end
                    if (e.typ == 3'd0 && !reads_seen) begin
                        reads_seen = 1;
                        nw = 0;
                        foreach (pend[j]) if (pend[j].typ == 3'd1) nw++;
                        n_vec++;
                        if (nw != 0) begin
                            n_err++;
                            $display("FAIL wb_before_rf inst%0d: got %0d writes unacked want 0", sel, nw);
                        end
                    end
                end
                pend.push_back('{rm[76:74], rm[73:66],
                                 (rm[76:74] == 3'd0) ? (rm[65:34] ^ salt) : 32'd0, cyc + 1});
            end
            if (pick >= 0 && prdy) begin
                if (mode == 2) void'(perm.pop_front());
                pend.delete(pick);
            end

            if (done_val[sel] === 1'b1) begin
                if (lat < 0) begin
                    lat = cyc;
                    n_vec++;
                    if (exp_q.size() != 0 || pend.size() != 0) begin
                        n_err++;
                        $display("FAIL early_done inst%0d: got done with %0d unissued %0d unanswered want 0/0",
                                 sel, exp_q.size(), pend.size());
                    end
                end
                n_vec++;
                if (done_data[sel] !== exp_line) begin
                    n_err++;
                    $display("FAIL done_data inst%0d: got %h want %h", sel, done_data[sel], exp_line);
                end
                done_rdy[sel] = (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
                fin = done_rdy[sel];
            end
            @(negedge clk);
            cyc++;
        end
        done_rdy[sel] = 1'b0;
        resp_val[sel] = 1'b0;
        req_rdy[sel]  = 1'b0;
        if (!fin) begin
            n_vec++;
            n_err++;
            $display("FAIL cmd_timeout inst%0d: got no completion in %0d cycles want completion", sel, cyc);
        end
        n_vec++;
        if (done_val[sel] !== 1'b0 || cmd_rdy[sel] !== 1'b1) begin
            n_err++;
            $display("FAIL post_done inst%0d: got done_val=%b cmd_rdy=%b want 0/1",
                     sel, done_val[sel], cmd_rdy[sel]);
        end
        model_line[sel] = exp_line;
    endtask

    task automatic test_reset();
        for (int s = 0; s < NI; s++) begin
            n_vec++;
            if ({cmd_rdy[s], done_val[s], req_val[s], resp_rdy[s]} !== 4'b1000) begin
                n_err++;
                $display("FAIL reset_ctrl inst%0d: got rdy/done/req/resp=%b%b%b%b want 1000",
                         s, cmd_rdy[s], done_val[s], req_val[s], resp_rdy[s]);
            end
            n_vec++;
            if (done_data[s] !== '0) begin
                n_err++;
                $display("FAIL reset_line inst%0d: got %h want 0", s, done_data[s]);
            end
        end
    endtask

    task automatic test_refill_inorder();
        int lat;
        run_cmd(0, 1'b0, 1'b1, $urandom, 32'h0000_1E24, '0, 0, lat);
        n_vec++;
        if (lat != LINE_WORDS + 2) begin
            n_err++;
            $display("FAIL refill_latency: got %0d want %0d", lat, LINE_WORDS + 2);
        end
    endtask

    task automatic test_refill_ooo();
        int lat;
        run_cmd(1, 1'b0, 1'b1, $urandom, $urandom, '0, 2, lat);
    endtask

    task automatic test_writeback();
        logic [LW-1:0] wd;
        int lat;
        for (int i = 0; i < LINE_WORDS; i++) wd[32*i +: 32] = 32'hDEAD_BEEF + 32'(i);
        run_cmd(0, 1'b1, 1'b0, 32'h0000_0040, $urandom, wd, 0, lat);
    endtask

    task automatic test_evict_refill();
        logic [LW-1:0] wd;
        int lat;
        for (int i = 0; i < LINE_WORDS; i++) wd[32*i +: 32] = $urandom;
        run_cmd(1, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0200, wd, 1, lat);
    endtask

    task automatic test_inflight_limit();
        logic [31:0] ra, base;
        logic [76:0] exp_msg;
        int fires;
        ra   = $urandom;
        base = ra & ~(32'(4 * LINE_WORDS) - 32'd1);
        cmd_val[0] = 1'b1; cmd_wb[0] = 1'b0; cmd_rf[0] = 1'b1; rf_addr[0] = ra;
        @(negedge clk);
        cmd_val[0] = 1'b0;
        req_rdy[0] = 1'b1;
        fires = 0;
        for (int c = 0; c < 6; c++) begin
            if (req_val[0] === 1'b1) fires++;
            @(negedge clk);
        end
        n_vec++;
        if (fires != 2 || req_val[0] !== 1'b0) begin
            n_err++;
            $display("FAIL inflight_cap: got %0d reqs, val=%b want 2 reqs, val=0", fires, req_val[0]);
        end
        resp_val[0] = 1'b1;
        resp_msg[0] = {3'd0, 8'd0, 4'h0, base ^ 32'h5A5A_0000};
        req_rdy[0]  = 1'b0;
        n_vec++;
        if (resp_rdy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL inflight_resp_rdy: got %b want 1", resp_rdy[0]);
        end
        @(negedge clk);
        resp_val[0] = 1'b0;
        exp_msg = {3'd0, 8'd2, base + 32'd8, 2'b00, 32'd0};
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (req_val[0] !== 1'b1 || req_msg[0] !== exp_msg) begin
                n_err++;
                $display("FAIL third_req_held c%0d: got val=%b msg=%h want val=1 msg=%h",
                         c, req_val[0], req_msg[0], exp_msg);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < NI; s++) model_line[s] = '0;
    endtask

    task automatic test_reset_midop();
        int fires, lat;
        cmd_val[0] = 1'b1; cmd_wb[0] = 1'b0; cmd_rf[0] = 1'b1; rf_addr[0] = $urandom;
        @(negedge clk);
        cmd_val[0] = 1'b0;
        req_rdy[0] = 1'b1;
        fires = 0;
        for (int c = 0; c < 10 && fires < 2; c++) begin
            if (req_val[0] === 1'b1) fires++;
            @(negedge clk);
        end
        req_rdy[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < NI; s++) model_line[s] = '0;
        n_vec++;
        if (fires != 2 || {cmd_rdy[0], req_val[0], done_val[0], resp_rdy[0]} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_midop: got reqs=%0d rdy/req/done/resp=%b%b%b%b want 2, 1000",
                     fires, cmd_rdy[0], req_val[0], done_val[0], resp_rdy[0]);
        end
        run_cmd(0, 1'b0, 1'b1, $urandom, $urandom, '0, 0, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        for (int r = 0; r < 3; r++) begin
            run_cmd(1, 1'b0, 1'b1, $urandom, $urandom, '0, 0, lat);
            n_vec++;
            if (lat != LINE_WORDS + 2) begin
                n_err++;
                $display("FAIL b2b_latency r%0d: got %0d want %0d", r, lat, LINE_WORDS + 2);
            end
        end
    endtask

    task automatic test_random();
        logic [LW-1:0] wd;
        int lat;
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < LINE_WORDS; i++) wd[32*i +: 32] = $urandom;
            run_cmd(r % NI, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, wd, 1, lat);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int s = 0; s < NI; s++) begin
            cmd_val[s] = 1'b0; cmd_wb[s] = 1'b0; cmd_rf[s] = 1'b0;
            wb_addr[s] = '0; rf_addr[s] = '0; wb_data[s] = '0;
            done_rdy[s] = 1'b0; req_rdy[s] = 1'b0;
            resp_val[s] = 1'b0; resp_msg[s] = '0;
            model_line[s] = '0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_refill_inorder();
        test_refill_ooo();
        test_writeback();
        test_evict_refill();
        test_inflight_limit();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of run by 400000 want earlier end");
        $fatal(1, "bench watchdog expired");
    end
endmodule
`default_nettype wire
